sipo_deser: RTL and testbench

Serial-to-parallel deserializer: the receiving end of the team's serial shift links. It accepts a qualified serial bit stream, assembles WIDTH-bit words, and presents each word on a parallel output with a valid/ready handshake. A one-word output holding register decouples the serial side from the consumer, and a sticky overflow flag reports lost words.

---
 rtl/sipo_deser.sv | 83 ++++++++
 tb/tb_sipo_deser.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deser.sv
// Serial-to-parallel deserializer: assembles WIDTH-bit words from a qualified bit stream
// and hands them to a consumer through a one-word valid/ready holding register.
module sipo_deser #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                       clk,
  input  logic                       clr_n,
  input  logic                       sin,
  input  logic                       sin_vld,
  input  logic                       frame_start,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_vld,
  input  logic                       dout_rdy,
  output logic                       overflow,
  input  logic                       ovf_clr,
  output logic [$clog2(WIDTH)-1:0]   bit_cnt
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] word;
  logic [CW-1:0]    cur;
  logic [CW-1:0]    pos;
  logic [CW-1:0]    cnt_nxt;
  logic             complete;
  logic             drop;

  // Each bit is written straight into its final slot, which gives the same word as
  // shifting; frame_start restarts the word from an empty register at bit 0.
  always_comb begin
    cur      = frame_start ? '0 : bit_cnt;
    pos      = MSB_FIRST ? (LAST_BIT - cur) : cur;
    word     = frame_start ? '0 : shreg;
    word[pos] = sin;
    complete = sin_vld && (cur == LAST_BIT);
    drop     = complete && dout_vld && !dout_rdy;
    cnt_nxt  = bit_cnt;
    if (sin_vld) begin
      cnt_nxt = complete ? '0 : cur + 1'b1;
    end else if (frame_start) begin
      cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      bit_cnt <= cnt_nxt;
      if (sin_vld) begin
        shreg <= complete ? '0 : word;
      end else if (frame_start) begin
        shreg <= '0;
      end
    end
  end

  // A completed word is dropped only when the holding register is full and not being drained.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      dout     <= '0;
      dout_vld <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (complete && (!dout_vld || dout_rdy)) begin
        dout     <= word;
        dout_vld <= 1'b1;
      end else if (!complete && dout_vld && dout_rdy) begin
        dout_vld <= 1'b0;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: LSB-first and MSB-first instances share one stimulus stream and
// are compared against a queue-based word model, plus directed checks of known words.
module tb_sipo_deser;

  localparam int W  = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          clr_n, sin, sin_vld, frame_start, dout_rdy, ovf_clr;
  logic [W-1:0]  dout_l, dout_m;
  logic          vld_l, vld_m, ovf_l, ovf_m;
  logic [CW-1:0] cnt_l, cnt_m;

  int n_assert = 0;
  int n_fail   = 0;

  bit m_bits[$];
  bit m_vld, m_ovf;
  int m_dout_l, m_dout_m;

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .clr_n(clr_n), .sin(sin), .sin_vld(sin_vld), .frame_start(frame_start),
    .dout(dout_l), .dout_vld(vld_l), .dout_rdy(dout_rdy), .overflow(ovf_l),
    .ovf_clr(ovf_clr), .bit_cnt(cnt_l)
  );

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .clr_n(clr_n), .sin(sin), .sin_vld(sin_vld), .frame_start(frame_start),
    .dout(dout_m), .dout_vld(vld_m), .dout_rdy(dout_rdy), .overflow(ovf_m),
    .ovf_clr(ovf_clr), .bit_cnt(cnt_m)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_bits.delete();
    m_vld    = 1'b0;
    m_ovf    = 1'b0;
    m_dout_l = 0;
    m_dout_m = 0;
  endtask

  // Words are collected as a list of received bits and valued by position once WIDTH arrive.
  task automatic modelEdge(input bit sv, input bit s, input bit fs, input bit rdy, input bit oc);
    bit done = 1'b0;
    int wl = 0;
    int wm = 0;
    if (fs) m_bits.delete();
    if (sv) m_bits.push_back(s);
    if (m_bits.size() == W) begin
      for (int i = 0; i < W; i++) begin
        wl += int'(m_bits[i]) * (1 << i);
        wm += int'(m_bits[i]) * (1 << (W - 1 - i));
      end
      done = 1'b1;
      m_bits.delete();
    end
    if (done && m_vld && !rdy) m_ovf = 1'b1;
    else if (oc)               m_ovf = 1'b0;
    if (done && (!m_vld || rdy)) begin
      m_vld    = 1'b1;
      m_dout_l = wl;
      m_dout_m = wm;
    end else if (!done && m_vld && rdy) begin
      m_vld = 1'b0;
    end
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, "_cnt_l"}, 32'(cnt_l), 32'(m_bits.size()));
    chk({tag, "_cnt_m"}, 32'(cnt_m), 32'(m_bits.size()));
    chk({tag, "_vld_l"}, 32'(vld_l), 32'(m_vld));
    chk({tag, "_vld_m"}, 32'(vld_m), 32'(m_vld));
    chk({tag, "_ovf_l"}, 32'(ovf_l), 32'(m_ovf));
    chk({tag, "_ovf_m"}, 32'(ovf_m), 32'(m_ovf));
    if (m_vld) begin
      chk({tag, "_dout_l"}, 32'(dout_l), 32'(m_dout_l));
      chk({tag, "_dout_m"}, 32'(dout_m), 32'(m_dout_m));
    end
  endtask

  task automatic applyStimulus(input string tag, input bit sv, input bit s, input bit fs,
                               input bit rdy, input bit oc);
    sin_vld     = sv;
    sin         = s;
    frame_start = fs;
    dout_rdy    = rdy;
    ovf_clr     = oc;
    @(posedge clk);
    modelEdge(sv, s, fs, rdy, oc);
    #1;
    checkOutput(tag);
  endtask

  task automatic sendWord(input string tag, input logic [W-1:0] w, input bit rdy);
    for (int i = 0; i < W; i++) applyStimulus(tag, 1'b1, w[i], 1'b0, rdy, 1'b0);
  endtask

  // Reset is pulled between clock edges so the outputs must clear without a clock.
  task automatic asyncReset(input string tag);
    clr_n = 1'b0;
    #2;
    modelReset();
    chk({tag, "_dout_l"}, 32'(dout_l), 32'h0);
    chk({tag, "_dout_m"}, 32'(dout_m), 32'h0);
    checkOutput(tag);
    #1;
    clr_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] rw;
    logic [W-1:0] exp_bits;
    clr_n = 1'b0; sin = 1'b0; sin_vld = 1'b0; frame_start = 1'b0;
    dout_rdy = 1'b0; ovf_clr = 1'b0;
    modelReset();
    #12;
    chk("rst_dout_l", 32'(dout_l), 32'h0);
    checkOutput("rst");
    #1 clr_n = 1'b1;

    $display("[TB] basic word, both bit orders");
    exp_bits = 4'b1101;
    for (int i = 0; i < W; i++) begin
      applyStimulus("t1", 1'b1, exp_bits[i], 1'b0, 1'b1, 1'b0);
      chk("t1_cnt_seq", 32'(cnt_l), 32'((i + 1) % W));
    end
    chk("t1_dout_lsb", 32'(dout_l), 32'hD);
    chk("t1_dout_msb", 32'(dout_m), 32'hB);
    chk("t1_vld", 32'(vld_l), 32'h1);
    applyStimulus("t1_idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t1_vld_one_cycle", 32'(vld_l), 32'h0);

    $display("[TB] gaps between bits");
    exp_bits = 4'b0011;
    for (int i = 0; i < W; i++) begin
      applyStimulus("t2", 1'b1, exp_bits[i], 1'b0, 1'b0, 1'b0);
      if (i < W - 1)
        for (int g = 0; g < 3; g++) applyStimulus("t2_gap", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    chk("t2_dout", 32'(dout_l), 32'h3);
    applyStimulus("t2_drain", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("[TB] overflow on stalled consumer");
    sendWord("t3a", 4'hA, 1'b0);
    sendWord("t3b", 4'h5, 1'b0);
    chk("t3_dout_kept", 32'(dout_l), 32'hA);
    chk("t3_ovf_set", 32'(ovf_l), 32'h1);
    applyStimulus("t3_clr", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t3_vld_clr", 32'(vld_l), 32'h0);
    chk("t3_ovf_clr", 32'(ovf_l), 32'h0);

    $display("[TB] back-to-back handoff");
    sendWord("t4a", 4'h9, 1'b0);
    exp_bits = 4'h6;
    for (int i = 0; i < W; i++)
      applyStimulus("t4b", 1'b1, exp_bits[i], 1'b0, (i == W - 1), 1'b0);
    chk("t4_dout", 32'(dout_l), 32'h6);
    chk("t4_vld", 32'(vld_l), 32'h1);
    chk("t4_ovf", 32'(ovf_l), 32'h0);
    applyStimulus("t4_drain", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("[TB] frame realign and async reset");
    applyStimulus("t5", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus("t5", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus("t5_fs", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t5_cnt_fs", 32'(cnt_l), 32'h1);
    applyStimulus("t5", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus("t5", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus("t5", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t5_dout", 32'(dout_l), 32'h9);
    applyStimulus("t5_fs_idle", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus("t5_fs_idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t5_cnt_fs_idle", 32'(cnt_l), 32'h0);
    applyStimulus("t6", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    asyncReset("t6_rst");
    rw = W'($urandom_range(0, (1 << W) - 1));
    sendWord("t6_clean", rw, 1'b1);
    chk("t6_dout_clean", 32'(dout_l), 32'(rw));

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      applyStimulus("rnd", ($urandom_range(0, 9) < 7), 1'($urandom), ($urandom_range(0, 19) == 0),
                    1'($urandom), ($urandom_range(0, 9) == 0));
      if (n == 200) asyncReset("rnd_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
